data_bus_adapter: RTL and testbench

DATA_BUS_ADAPTER -- requirements
Module: data_bus_adapter

---
 rtl/data_bus_adapter_pkg.sv | 34 +++
 rtl/byte_lane_unit.sv | 69 ++++++
 rtl/data_bus_adapter.sv | 145 ++++++++++++++
 tb/tb_data_bus_adapter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_bus_adapter_pkg.sv
// data_bus_adapter_pkg
// Shared definitions for the data bus adapter: controller state encoding,
// access size codes and the request legality check used in IDLE.
// No ports (package).

package data_bus_adapter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10,
    ST_FAULT  = 2'b11
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  // A request is rejected when its size is reserved or its address is not
  // naturally aligned for that size. Bytes are always aligned.
  function automatic logic is_bad_request(input logic [1:0] size,
                                          input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// byte_lane_unit
// Purely combinational lane steering for the data bus adapter.
// Ports:
//   size        - access size code (SZ_BYTE/SZ_HALF/SZ_WORD)
//   signed_load - sign-extend byte/half load results
//   addr_lo     - low two address bits selecting the lane(s)
//   store_data  - right-aligned store data
//   bus_word    - raw 32-bit word read from the bus
//   byte_enable - little-endian lane enables (unqualified by state)
//   lane_data   - store data replicated across all lanes
//   load_data   - selected lane shifted to bit 0 and extended

module byte_lane_unit
  import data_bus_adapter_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        signed_load,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] bus_word,
  output logic [3:0]  byte_enable,
  output logic [31:0] lane_data,
  output logic [31:0] load_data
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Pick the addressed byte and halfword out of the bus word.
  always_comb begin
    sel_byte = bus_word[7:0];
    case (addr_lo)
      2'b00:   sel_byte = bus_word[7:0];
      2'b01:   sel_byte = bus_word[15:8];
      2'b10:   sel_byte = bus_word[23:16];
      default: sel_byte = bus_word[31:24];
    endcase
    sel_half = addr_lo[1] ? bus_word[31:16] : bus_word[15:0];
  end

  // Replicating store data means the bus slave only needs the enables to
  // know which lanes to write; word loads pass through unextended.
  always_comb begin
    byte_enable = 4'b0000;
    lane_data   = store_data;
    load_data   = bus_word;
    case (size)
      SZ_BYTE: begin
        byte_enable = 4'b0001 << addr_lo;
        lane_data   = {4{store_data[7:0]}};
        load_data   = {{24{signed_load & sel_byte[7]}}, sel_byte};
      end
      SZ_HALF: begin
        byte_enable = addr_lo[1] ? 4'b1100 : 4'b0011;
        lane_data   = {2{store_data[15:0]}};
        load_data   = {{16{signed_load & sel_half[15]}}, sel_half};
      end
      SZ_WORD: begin
        byte_enable = 4'b1111;
        lane_data   = store_data;
        load_data   = bus_word;
      end
      default: begin
        byte_enable = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/data_bus_adapter.sv
// data_bus_adapter
// Turns a single datapath load/store request into a fixed-latency word bus
// access with lane enables, replicated store data and extended load data.
// Ports:
//   iCLK, iRST            - clock, synchronous active-low reset
//   iReq, iWrite, iSize,
//   iSigned, iAddress,
//   iWriteData            - request from the datapath, sampled only in IDLE
//   oBusy, oDone, oFault  - status back to the datapath
//   oReadData             - extended load result, held until the next load
//   DwReadEnable,
//   DwWriteEnable,
//   DwByteEnable,
//   DwAddress,
//   DwWriteData           - bus strobes, lanes, word address and data
//   DwReadData            - bus read word

module data_bus_adapter
  import data_bus_adapter_pkg::*;
#(
  parameter int WAIT_STATES = 1
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iReq,
  input  logic        iWrite,
  input  logic [1:0]  iSize,
  input  logic        iSigned,
  input  logic [31:0] iAddress,
  input  logic [31:0] iWriteData,
  output logic        oBusy,
  output logic        oDone,
  output logic        oFault,
  output logic [31:0] oReadData,
  output logic        DwReadEnable,
  output logic        DwWriteEnable,
  output logic [3:0]  DwByteEnable,
  output logic [31:0] DwAddress,
  output logic [31:0] DwWriteData,
  input  logic [31:0] DwReadData
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  state_t      state, state_next;
  logic [3:0]  wait_count;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic        write_q;

  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] lane_rdata;
  logic        bad_req;
  logic        accept;
  logic        last_beat;

  assign bad_req   = is_bad_request(iSize, iAddress[1:0]);
  assign accept    = (state == ST_IDLE) && iReq && !bad_req;
  assign last_beat = (state == ST_ACCESS) && (wait_count == 4'd0);

  byte_lane_unit u_lanes (
    .size        (size_q),
    .signed_load (signed_q),
    .addr_lo     (addr_q[1:0]),
    .store_data  (wdata_q),
    .bus_word    (DwReadData),
    .byte_enable (lane_be),
    .lane_data   (lane_wdata),
    .load_data   (lane_rdata)
  );

  // State register.
  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: rejected requests take a one-cycle detour through FAULT so
  // the datapath still sees oBusy and never any bus strobe.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (iReq) begin
          state_next = bad_req ? ST_FAULT : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (wait_count == 4'd0) begin
          state_next = ST_RESP;
        end
      end
      ST_RESP:  state_next = ST_IDLE;
      ST_FAULT: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Request capture, wait counting and load result. The request is frozen
  // at acceptance so the datapath may change its inputs while we are busy.
  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      wait_count <= 4'd0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      size_q     <= SZ_BYTE;
      signed_q   <= 1'b0;
      write_q    <= 1'b0;
      oReadData  <= 32'h0;
    end else begin
      if (accept) begin
        addr_q     <= iAddress;
        wdata_q    <= iWriteData;
        size_q     <= iSize;
        signed_q   <= iSigned;
        write_q    <= iWrite;
        wait_count <= WAIT_INIT;
      end else if ((state == ST_ACCESS) && (wait_count != 4'd0)) begin
        wait_count <= wait_count - 4'd1;
      end
      if (last_beat && !write_q) begin
        oReadData <= lane_rdata;
      end
    end
  end

  // Outputs decode straight from the registered state.
  always_comb begin
    oBusy         = (state != ST_IDLE);
    oDone         = (state == ST_RESP);
    oFault        = (state == ST_FAULT);
    DwReadEnable  = (state == ST_ACCESS) && !write_q;
    DwWriteEnable = (state == ST_ACCESS) && write_q;
    DwByteEnable  = (state == ST_ACCESS) ? lane_be : 4'b0000;
    DwAddress     = {addr_q[31:2], 2'b00};
    DwWriteData   = lane_wdata;
  end

endmodule

// File: tb/tb_data_bus_adapter.sv
// tb_data_bus_adapter
// Self-checking bench for data_bus_adapter. The main instance uses
// WAIT_STATES=1; a second instance with WAIT_STATES=0 shares the request
// inputs but has its own request line for the back-to-back sequence.

module tb_data_bus_adapter;
  import data_bus_adapter_pkg::*;

  localparam int WS = 1;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b0;
  logic        iReq = 1'b0;
  logic        iReq0 = 1'b0;
  logic        iWrite = 1'b0;
  logic [1:0]  iSize = 2'b00;
  logic        iSigned = 1'b0;
  logic [31:0] iAddress = 32'h0;
  logic [31:0] iWriteData = 32'h0;
  logic [31:0] DwReadData = 32'h0;

  logic        oBusy, oDone, oFault;
  logic [31:0] oReadData;
  logic        DwReadEnable, DwWriteEnable;
  logic [3:0]  DwByteEnable;
  logic [31:0] DwAddress, DwWriteData;

  logic        oBusy0, oDone0, oFault0;
  logic [31:0] oReadData0;
  logic        DwReadEnable0, DwWriteEnable0;
  logic [3:0]  DwByteEnable0;
  logic [31:0] DwAddress0, DwWriteData0;

  always #5 iCLK = ~iCLK;

  data_bus_adapter #(.WAIT_STATES(WS)) dut (
    .iCLK          (iCLK),
    .iRST          (iRST),
    .iReq          (iReq),
    .iWrite        (iWrite),
    .iSize         (iSize),
    .iSigned       (iSigned),
    .iAddress      (iAddress),
    .iWriteData    (iWriteData),
    .oBusy         (oBusy),
    .oDone         (oDone),
    .oFault        (oFault),
    .oReadData     (oReadData),
    .DwReadEnable  (DwReadEnable),
    .DwWriteEnable (DwWriteEnable),
    .DwByteEnable  (DwByteEnable),
    .DwAddress     (DwAddress),
    .DwWriteData   (DwWriteData),
    .DwReadData    (DwReadData)
  );

  data_bus_adapter #(.WAIT_STATES(0)) dut0 (
    .iCLK          (iCLK),
    .iRST          (iRST),
    .iReq          (iReq0),
    .iWrite        (iWrite),
    .iSize         (iSize),
    .iSigned       (iSigned),
    .iAddress      (iAddress),
    .iWriteData    (iWriteData),
    .oBusy         (oBusy0),
    .oDone         (oDone0),
    .oFault        (oFault0),
    .oReadData     (oReadData0),
    .DwReadEnable  (DwReadEnable0),
    .DwWriteEnable (DwWriteEnable0),
    .DwByteEnable  (DwByteEnable0),
    .DwAddress     (DwAddress0),
    .DwWriteData   (DwWriteData0),
    .DwReadData    (DwReadData)
  );

  typedef struct {
    logic        write;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] busWord;
    logic        expFault;
    logic [3:0]  expBe;
    logic [31:0] expAddr;
    logic [31:0] expWdata;
    logic [31:0] expRdata;
  } vec_t;

  localparam int NVEC = 14;
  vec_t        vecs [NVEC];
  vec_t        scoreboard [$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] lastRdata = 32'h0;

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one request for a single accepting edge, then scramble the inputs
  // to show that changes while busy are ignored.
  task automatic applyStimulus(input vec_t v);
    iWrite     = v.write;
    iSize      = v.size;
    iSigned    = v.sgn;
    iAddress   = v.addr;
    iWriteData = v.wdata;
    DwReadData = v.busWord;
    iReq       = 1'b1;
    scoreboard.push_back(v);
    @(posedge iCLK);
    #1;
    iReq       = 1'b0;
    iWrite     = 1'($urandom_range(0, 1));
    iSize      = 2'($urandom_range(0, 3));
    iSigned    = 1'($urandom_range(0, 1));
    iAddress   = $urandom();
    iWriteData = $urandom();
  endtask

  // Follow the transaction cycle by cycle until oDone/oFault, then compare
  // against the oldest scoreboard entry.
  task automatic checkOutput(input int idx);
    vec_t        e;
    int          doneCycle = 0;
    int          strobes = 0;
    logic        seen = 1'b0;
    logic        gotFault = 1'b0;
    logic        bothHigh = 1'b0;
    logic        busyHeld = 1'b1;
    logic        wrSeen = 1'b0;
    logic        rdSeen = 1'b0;
    logic        dualStrobe = 1'b0;
    logic [3:0]  be = 4'h0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wd = 32'h0;
    logic [31:0] rdata = 32'h0;
    logic [31:0] expRd;
    string       tag;
    tag = $sformatf("vec%0d", idx);
    for (int k = 1; k <= 20 && !seen; k++) begin
      if (DwReadEnable || DwWriteEnable) begin
        strobes++;
        be = DwByteEnable;
        addr = DwAddress;
        wd = DwWriteData;
        wrSeen = wrSeen | DwWriteEnable;
        rdSeen = rdSeen | DwReadEnable;
        dualStrobe = dualStrobe | (DwReadEnable & DwWriteEnable);
      end
      if (!oBusy) busyHeld = 1'b0;
      if (oDone || oFault) begin
        seen = 1'b1;
        doneCycle = k;
        gotFault = oFault;
        bothHigh = oDone & oFault;
        rdata = oReadData;
      end else begin
        @(posedge iCLK);
        #1;
      end
    end
    if (scoreboard.size() == 0) begin
      checkValue({tag, " scoreboard_empty"}, 32'd1, 32'd0);
      return;
    end
    e = scoreboard.pop_front();
    checkValue({tag, " response_seen"}, 32'(seen), 32'd1);
    if (!seen) return;
    checkValue({tag, " fault_flag"}, 32'(gotFault), 32'(e.expFault));
    checkValue({tag, " done_and_fault"}, 32'(bothHigh), 32'd0);
    checkValue({tag, " latency"}, 32'(doneCycle), e.expFault ? 32'd1 : 32'(WS + 2));
    checkValue({tag, " busy_held"}, 32'(busyHeld), 32'd1);
    checkValue({tag, " strobe_cycles"}, 32'(strobes), e.expFault ? 32'd0 : 32'(WS + 1));
    checkValue({tag, " dual_strobe"}, 32'(dualStrobe), 32'd0);
    if (!e.expFault) begin
      checkValue({tag, " byte_enable"}, 32'(be), 32'(e.expBe));
      checkValue({tag, " bus_address"}, addr, e.expAddr);
      checkValue({tag, " write_strobe"}, 32'(wrSeen), 32'(e.write));
      checkValue({tag, " read_strobe"}, 32'(rdSeen), 32'(!e.write));
      if (e.write) checkValue({tag, " write_data"}, wd, e.expWdata);
    end
    expRd = (!e.write && !e.expFault) ? e.expRdata : lastRdata;
    checkValue({tag, " read_data"}, rdata, expRd);
    lastRdata = expRd;
    @(posedge iCLK);
    #1;
    checkValue({tag, " pulse_done_low"}, 32'(oDone | oFault), 32'd0);
    checkValue({tag, " idle_after"}, 32'(oBusy), 32'd0);
    checkValue({tag, " be_idle"}, 32'(DwByteEnable), 32'd0);
  endtask

  initial begin
    int doneCount;
    int firstDone;
    int secondDone;
    int strobes0;
    logic [31:0] rd0;

    vecs[0]  = '{1'b1, SZ_WORD, 1'b0, 32'h0000_1004, 32'hDEAD_BEEF, 32'h0,         1'b0, 4'b1111, 32'h0000_1004, 32'hDEAD_BEEF, 32'h0};
    vecs[1]  = '{1'b0, SZ_BYTE, 1'b1, 32'h0000_2003, 32'h0,         32'h8011_2233, 1'b0, 4'b1000, 32'h0000_2000, 32'h0,         32'hFFFF_FF80};
    vecs[2]  = '{1'b0, SZ_BYTE, 1'b0, 32'h0000_2003, 32'h0,         32'h8011_2233, 1'b0, 4'b1000, 32'h0000_2000, 32'h0,         32'h0000_0080};
    vecs[3]  = '{1'b1, SZ_HALF, 1'b0, 32'h0000_2002, 32'h0000_ABCD, 32'h0,         1'b0, 4'b1100, 32'h0000_2000, 32'hABCD_ABCD, 32'h0};
    vecs[4]  = '{1'b0, SZ_WORD, 1'b0, 32'h0000_2002, 32'h0,         32'h0,         1'b1, 4'b0000, 32'h0,         32'h0,         32'h0};
    vecs[5]  = '{1'b0, SZ_RSVD, 1'b0, 32'h0000_2000, 32'h0,         32'h0,         1'b1, 4'b0000, 32'h0,         32'h0,         32'h0};
    vecs[6]  = '{1'b0, SZ_HALF, 1'b1, 32'h0000_3000, 32'h0,         32'h1234_8765, 1'b0, 4'b0011, 32'h0000_3000, 32'h0,         32'hFFFF_8765};
    vecs[7]  = '{1'b0, SZ_HALF, 1'b0, 32'h0000_3002, 32'h0,         32'h8765_1234, 1'b0, 4'b1100, 32'h0000_3000, 32'h0,         32'h0000_8765};
    vecs[8]  = '{1'b1, SZ_BYTE, 1'b0, 32'h0000_4001, 32'h0000_00A5, 32'h0,         1'b0, 4'b0010, 32'h0000_4000, 32'hA5A5_A5A5, 32'h0};
    vecs[9]  = '{1'b0, SZ_WORD, 1'b1, 32'h0000_5008, 32'h0,         32'h89AB_CDEF, 1'b0, 4'b1111, 32'h0000_5008, 32'h0,         32'h89AB_CDEF};
    vecs[10] = '{1'b0, SZ_HALF, 1'b1, 32'h0000_3001, 32'h0,         32'h0,         1'b1, 4'b0000, 32'h0,         32'h0,         32'h0};
    vecs[11] = '{1'b0, SZ_BYTE, 1'b1, 32'h0000_6001, 32'h0,         32'h0000_7F00, 1'b0, 4'b0010, 32'h0000_6000, 32'h0,         32'h0000_007F};
    vecs[12] = '{1'b1, SZ_BYTE, 1'b0, 32'h0000_7002, 32'h1234_5678, 32'h0,         1'b0, 4'b0100, 32'h0000_7000, 32'h7878_7878, 32'h0};
    vecs[13] = '{1'b1, SZ_HALF, 1'b1, 32'h0000_8006, 32'hFFFF_1357, 32'h0,         1'b0, 4'b1100, 32'h0000_8004, 32'h1357_1357, 32'h0};

    // Reset state.
    repeat (3) @(posedge iCLK);
    #1;
    checkValue("reset busy", 32'(oBusy), 32'd0);
    checkValue("reset done", 32'(oDone), 32'd0);
    checkValue("reset fault", 32'(oFault), 32'd0);
    checkValue("reset strobes", 32'({DwReadEnable, DwWriteEnable}), 32'd0);
    checkValue("reset byte_enable", 32'(DwByteEnable), 32'd0);
    checkValue("reset read_data", oReadData, 32'h0);
    iRST = 1'b1;
    @(posedge iCLK);
    #1;

    // Table-driven single transactions.
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(i);
    end

    // Reset in the middle of an ACCESS: strobes drop next cycle, no oDone.
    iWrite = 1'b1; iSize = SZ_WORD; iSigned = 1'b0;
    iAddress = 32'h0000_9000; iWriteData = 32'h1111_2222;
    iReq = 1'b1;
    @(posedge iCLK);
    #1;
    iReq = 1'b0;
    checkValue("midreset strobe_before", 32'(DwWriteEnable), 32'd1);
    iRST = 1'b0;
    @(posedge iCLK);
    #1;
    checkValue("midreset strobes_low", 32'({DwReadEnable, DwWriteEnable}), 32'd0);
    checkValue("midreset byte_enable", 32'(DwByteEnable), 32'd0);
    checkValue("midreset busy", 32'(oBusy), 32'd0);
    checkValue("midreset done", 32'(oDone), 32'd0);
    checkValue("midreset read_data", oReadData, 32'h0);
    lastRdata = 32'h0;
    iRST = 1'b1;
    doneCount = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge iCLK);
      #1;
      if (oDone) doneCount++;
    end
    checkValue("midreset no_done", 32'(doneCount), 32'd0);

    // Back-to-back loads on the zero-wait instance with iReq0 held across
    // the busy window: exactly two accesses, oDone pulses 3 cycles apart.
    iWrite = 1'b0; iSize = SZ_WORD; iSigned = 1'b0;
    iAddress = 32'h0000_0100; DwReadData = 32'hCAFE_F00D;
    iReq0 = 1'b1;
    doneCount = 0; firstDone = 0; secondDone = 0; strobes0 = 0; rd0 = 32'h0;
    for (int k = 1; k <= 14; k++) begin
      @(posedge iCLK);
      #1;
      if (DwReadEnable0) strobes0++;
      if (oDone0) begin
        doneCount++;
        if (doneCount == 1) begin
          firstDone = k;
          rd0 = oReadData0;
        end else if (doneCount == 2) begin
          secondDone = k;
        end
      end
      if (k == 4) iReq0 = 1'b0;
    end
    checkValue("b2b done_count", 32'(doneCount), 32'd2);
    checkValue("b2b first_latency", 32'(firstDone), 32'd2);
    checkValue("b2b spacing", 32'(secondDone - firstDone), 32'd3);
    checkValue("b2b strobe_cycles", 32'(strobes0), 32'd2);
    checkValue("b2b read_data", rd0, 32'hCAFE_F00D);
    checkValue("b2b main_idle", 32'(oBusy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
